// File: rtl/mux_nx1_flop_rr_pkg.sv
// Shared definitions for the N-channel registered mux: mode encodings,
// default sizing and the modulo-CHANNELS index helper.
package mux_nx1_flop_rr_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   localparam int DEF_WIDTH    = 2;
   localparam int DEF_CHANNELS = 4;

   // idx is always below 2*n here, so one conditional subtract gives idx mod n
   function automatic int wrap_idx(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/mux_nx1_flop_rr_rr_arbiter.sv
// Combinational round-robin search: first valid channel after ptr,
// wrapping modulo CHANNELS and ending at ptr itself.
module rr_arbiter
   import mux_nx1_flop_rr_pkg::*;
#(
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] in_valid,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                grant_any
);

   int idx;

   // Walk from the farthest offset down so the nearest valid channel
   // after ptr is the last (winning) assignment.
   always_comb begin
      grant_idx = ptr;
      grant_any = 1'b0;
      idx       = 0;
      for (int off = CHANNELS; off >= 1; off--) begin
         idx = wrap_idx(int'(ptr) + off, CHANNELS);
         if (in_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mux_nx1_flop_rr.sv
// N-channel, W-bit registered mux with manual and round-robin selection;
// data, valid and served index all leave from flops.
module mux_nx1_flop_rr
   import mux_nx1_flop_rr_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset_L,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          selector,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]          data_out,
   output logic                      valid_out,
   output logic [SEL_W-1:0]          sel_out
);

   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic [SEL_W-1:0] ptr_q,   ptr_d;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_any;

   rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .in_valid  (in_valid),
      .ptr       (ptr_q),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (enable) begin
         if (mode == MODE_MANUAL) begin
            sel_d = selector;
            // Unused selector codes exist when CHANNELS is not a power of two
            if (32'(selector) < 32'(CHANNELS)) begin
               data_d  = data_in[int'(selector)*WIDTH +: WIDTH];
               valid_d = in_valid[selector];
            end else begin
               data_d  = '0;
               valid_d = 1'b0;
            end
         end else begin
            valid_d = grant_any;
            if (grant_any) begin
               data_d = data_in[int'(grant_idx)*WIDTH +: WIDTH];
               sel_d  = grant_idx;
               ptr_d  = grant_idx;
            end
         end
      end
   end

   // ptr resets to the last channel so the first search starts at channel 0
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         sel_q   <= '0;
         ptr_q   <= SEL_W'(CHANNELS-1);
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign sel_out   = sel_q;

endmodule
